// File: rtl/decompressor_feed_ctrl.sv
// decompressor_feed_ctrl
//   Sequencer between a valid/ready compressed-word source and the decompressor.
//   Each group is one control word followed by up to CW_BITS items. Each item
//   goes to the decompressor with one flag bit, taken MSB first from the control
//   word. Items are issued one at a time and paced by dec_busy. A zero item word
//   ends the stream. A zero control word is not a terminator; it means a group of
//   literals.
//
// Ports
//   clock, reset          system clock, asynchronous active-low reset
//   start                 one-cycle pulse, only honoured in IDLE
//   in_word/in_valid      source word and its valid
//   in_ready              source pop strobe (handshake = in_valid && in_ready)
//   dec_data_in           item word to the decompressor (held outside ISSUE)
//   dec_control_word_in   item flag: 1 = copy, 0 = literal (held outside ISSUE)
//   dec_data_in_valid     one-cycle issue strobe, never asserted while dec_busy
//   dec_busy              decompressor busy
//   items_issued          items issued in the current stream
//   done                  one-cycle end-of-stream pulse
//   error                 sticky item-limit overflow flag, cleared by start
//
// Configuration
//   FEED_STATS_EN  adds the literal_cnt / copy_cnt outputs. Together they always
//                  sum to items_issued.
module decompressor_feed_ctrl #(
   parameter int CW_BITS   = 8,
   parameter int MAX_ITEMS = 4096,
   localparam int CNT_W    = $clog2(MAX_ITEMS) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      in_word,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      dec_data_in,
   output logic             dec_control_word_in,
   output logic             dec_data_in_valid,
   input  logic             dec_busy,
   output logic [CNT_W-1:0] items_issued,
   output logic             done,
   output logic             error
`ifdef FEED_STATS_EN
   ,
   output logic [CNT_W-1:0] literal_cnt,
   output logic [CNT_W-1:0] copy_cnt
`endif
);

   localparam int BIT_W = $clog2(CW_BITS + 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FETCH_CW   = 3'd1,
      ST_FETCH_ITEM = 3'd2,
      ST_ISSUE      = 3'd3,
      ST_SETTLE     = 3'd4,
      ST_WAIT       = 3'd5,
      ST_DONE       = 3'd6
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [CW_BITS-1:0] cw_shift_r;
   logic [BIT_W-1:0]   bit_cnt_r;
   logic [CNT_W-1:0]   items_r;
   logic               err_r;
   logic [15:0]        data_r;
   logic               flag_r;
   logic               in_ready_s;
   logic               issue_s;
   logic               at_limit_s;
`ifdef FEED_STATS_EN
   logic [CNT_W-1:0]   lit_r;
   logic [CNT_W-1:0]   copy_r;
`endif

   assign at_limit_s = (items_r == CNT_W'(MAX_ITEMS));

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode, source pop strobe and issue strobe
   always_comb begin
      next_state_s = state_r;
      in_ready_s   = 1'b0;
      issue_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               next_state_s = ST_FETCH_CW;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_FETCH_CW: begin
            in_ready_s = 1'b1;
            if (in_valid) begin
               next_state_s = ST_FETCH_ITEM;
            end else begin
               next_state_s = ST_FETCH_CW;
            end
         end
         ST_FETCH_ITEM: begin
            in_ready_s = 1'b1;
            if (in_valid) begin
               // A terminator and an over-limit item both end the stream.
               if (in_word == 16'h0000) begin
                  next_state_s = ST_DONE;
               end else if (at_limit_s) begin
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_ISSUE;
               end
            end else begin
               next_state_s = ST_FETCH_ITEM;
            end
         end
         ST_ISSUE: begin
            if (!dec_busy) begin
               issue_s      = 1'b1;
               next_state_s = ST_SETTLE;
            end else begin
               next_state_s = ST_ISSUE;
            end
         end
         // The decompressor raises busy one cycle after it accepts an item,
         // so busy is not looked at here.
         ST_SETTLE: begin
            next_state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (!dec_busy) begin
               if (bit_cnt_r == BIT_W'(CW_BITS)) begin
                  next_state_s = ST_FETCH_CW;
               end else begin
                  next_state_s = ST_FETCH_ITEM;
               end
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Datapath: control-word shifter, item latch, counters and error flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cw_shift_r <= '0;
         bit_cnt_r  <= '0;
         items_r    <= '0;
         err_r      <= 1'b0;
         data_r     <= 16'h0000;
         flag_r     <= 1'b0;
`ifdef FEED_STATS_EN
         lit_r      <= '0;
         copy_r     <= '0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  items_r <= '0;
                  err_r   <= 1'b0;
`ifdef FEED_STATS_EN
                  lit_r   <= '0;
                  copy_r  <= '0;
`endif
               end
            end
            ST_FETCH_CW: begin
               if (in_valid) begin
                  cw_shift_r <= in_word[CW_BITS-1:0];
                  bit_cnt_r  <= '0;
               end
            end
            ST_FETCH_ITEM: begin
               if (in_valid && (in_word != 16'h0000)) begin
                  if (at_limit_s) begin
                     err_r <= 1'b1;
                  end else begin
                     data_r <= in_word;
                     flag_r <= cw_shift_r[CW_BITS-1];
                  end
               end
            end
            ST_ISSUE: begin
               if (issue_s) begin
                  items_r    <= items_r + CNT_W'(1);
                  cw_shift_r <= {cw_shift_r[CW_BITS-2:0], 1'b0};
                  bit_cnt_r  <= bit_cnt_r + BIT_W'(1);
`ifdef FEED_STATS_EN
                  if (flag_r) begin
                     copy_r <= copy_r + CNT_W'(1);
                  end else begin
                     lit_r  <= lit_r + CNT_W'(1);
                  end
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready            = in_ready_s;
   assign dec_data_in         = data_r;
   assign dec_control_word_in = flag_r;
   assign dec_data_in_valid   = issue_s;
   assign items_issued        = items_r;
   assign done                = (state_r == ST_DONE);
   assign error               = err_r;
`ifdef FEED_STATS_EN
   assign literal_cnt         = lit_r;
   assign copy_cnt            = copy_r;
`endif

endmodule

// File: tb/tb_decompressor_feed_ctrl.sv
// tb_decompressor_feed_ctrl
//   Random and directed streams checked against a stream-level reference model.
//   The model walks the word list group by group and produces the item/flag
//   sequence, item count, error flag and number of words consumed.
module tb_decompressor_feed_ctrl;

   localparam int CW_BITS   = 8;
   localparam int MAX_ITEMS = 16;
   localparam int CNT_W     = $clog2(MAX_ITEMS) + 1;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [15:0]      in_word = 16'h0000;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      dec_data_in;
   logic             dec_control_word_in;
   logic             dec_data_in_valid;
   logic             dec_busy = 1'b0;
   logic [CNT_W-1:0] items_issued;
   logic             done;
   logic             error;
`ifdef FEED_STATS_EN
   logic [CNT_W-1:0] literal_cnt;
   logic [CNT_W-1:0] copy_cnt;
`endif

   always #5 clock = ~clock;

   decompressor_feed_ctrl #(.CW_BITS(CW_BITS), .MAX_ITEMS(MAX_ITEMS)) dut (
      .clock               (clock),
      .reset               (reset),
      .start               (start),
      .in_word             (in_word),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .dec_data_in         (dec_data_in),
      .dec_control_word_in (dec_control_word_in),
      .dec_data_in_valid   (dec_data_in_valid),
      .dec_busy            (dec_busy),
      .items_issued        (items_issued),
      .done                (done),
      .error               (error)
`ifdef FEED_STATS_EN
      ,
      .literal_cnt         (literal_cnt),
      .copy_cnt            (copy_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] words[$];
   int          roles[$];      // 0 control, 1 item, 2 terminator, 3 overflow
   logic [15:0] exp_data[$];
   logic        exp_flag[$];
   int          exp_issued;
   int          exp_consumed;
   int          exp_lit;
   int          exp_copy;
   logic        exp_err;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Stream-level reference: groups of one control word plus up to CW_BITS items.
   function automatic void model();
      int p;
      bit fin;
      logic [CW_BITS-1:0] cw;
      exp_data.delete(); exp_flag.delete(); roles.delete();
      exp_issued = 0; exp_err = 1'b0; exp_lit = 0; exp_copy = 0;
      p = 0; fin = 1'b0;
      while (!fin && p < words.size()) begin
         cw = words[p][CW_BITS-1:0];
         roles.push_back(0);
         p++;
         for (int b = 0; b < CW_BITS && !fin && p < words.size(); b++) begin
            if (words[p] == 16'h0000) begin
               roles.push_back(2); fin = 1'b1;
            end else if (exp_issued == MAX_ITEMS) begin
               roles.push_back(3); exp_err = 1'b1; fin = 1'b1;
            end else begin
               exp_data.push_back(words[p]);
               exp_flag.push_back(cw[CW_BITS-1-b]);
               if (cw[CW_BITS-1-b]) exp_copy++; else exp_lit++;
               exp_issued++;
               roles.push_back(1);
            end
            p++;
         end
      end
      exp_consumed = p;
   endfunction

   function automatic logic [15:0] rand_cw();
      return ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
   endfunction

   task automatic gen_random(input int n_items);
      int left;
      words.delete();
      left = n_items;
      while (left > 0) begin
         words.push_back(rand_cw());
         for (int k = 0; k < CW_BITS && left > 0; k++) begin
            words.push_back(16'($urandom_range(1, 16'hFFFF)));
            left--;
         end
      end
      // After a full group the next word is a control word, never a terminator.
      if (n_items % CW_BITS == 0) words.push_back(rand_cw());
      words.push_back(16'h0000);
   endtask

   task automatic check_idle_outputs(input string pfx);
      check_val({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
      check_val({pfx, "_valid"}, 32'(dec_data_in_valid), 32'd0);
      check_val({pfx, "_data"}, 32'(dec_data_in), 32'd0);
      check_val({pfx, "_flag"}, 32'(dec_control_word_in), 32'd0);
      check_val({pfx, "_items"}, 32'(items_issued), 32'd0);
      check_val({pfx, "_done"}, 32'(done), 32'd0);
      check_val({pfx, "_error"}, 32'(error), 32'd0);
`ifdef FEED_STATS_EN
      check_val({pfx, "_lit"}, 32'(literal_cnt), 32'd0);
      check_val({pfx, "_copy"}, 32'(copy_cnt), 32'd0);
`endif
   endtask

   task automatic run_stream(input int min_busy, input int max_busy, input int gap_pct, input bit spurious);
      int  pos, got, done_cnt, busy_cnt, spur_left, exp_valid_cyc;
      bit  spur_on, finished;
      model();
      pos = 0; got = 0; done_cnt = 0; busy_cnt = 0; spur_left = 0;
      exp_valid_cyc = -1; finished = 1'b0; spur_on = 1'b0;
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         @(negedge clock);
         // The extra pulse lands mid-stream and must be ignored.
         start = (cyc == 0) || (cyc == 5);
         if (pos < words.size()) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
         end else begin
            in_valid = 1'b0;
         end
         in_word = in_valid ? words[pos] : 16'($urandom);
         if (spur_left > 0) begin
            dec_busy = 1'b1; spur_left--; spur_on = 1'b1;
         end else if (busy_cnt > 0) begin
            dec_busy = 1'b1; busy_cnt--; spur_on = 1'b0;
         end else begin
            dec_busy = 1'b0; spur_on = 1'b0;
         end
         #1;
         if (cyc == 1) begin
            check_val("start_clr_items", 32'(items_issued), 32'd0);
            check_val("start_clr_error", 32'(error), 32'd0);
         end
         check_val("rdy_while_busy", 32'(in_ready & dec_busy), 32'd0);
         if (spur_on && got < exp_data.size()) begin
            check_val("hold_valid", 32'(dec_data_in_valid), 32'd0);
            check_val("hold_data", 32'(dec_data_in), 32'(exp_data[got]));
            check_val("hold_flag", 32'(dec_control_word_in), 32'(exp_flag[got]));
         end
         if (dec_data_in_valid) begin
            if (got < exp_data.size()) begin
               check_val("issue_data", 32'(dec_data_in), 32'(exp_data[got]));
               check_val("issue_flag", 32'(dec_control_word_in), 32'(exp_flag[got]));
               check_val("issue_latency", 32'(cyc), 32'(exp_valid_cyc));
            end else begin
               check_val("extra_issue", 32'(got), 32'(exp_data.size()));
            end
            got++;
            busy_cnt = $urandom_range(min_busy, max_busy);
         end
         if (in_valid && in_ready) begin
            if (pos < roles.size() && roles[pos] == 1) begin
               spur_left = spurious ? $urandom_range(0, 2) : 0;
               exp_valid_cyc = cyc + 1 + spur_left;
            end
            pos++;
         end
         if (done) begin
            done_cnt++;
            finished = 1'b1;
         end
      end
      check_val("done_seen", 32'(done_cnt), 32'd1);
      start = 1'b0;
      for (int t = 0; t < 3; t++) begin
         @(negedge clock);
         in_valid = (pos < words.size());
         in_word  = in_valid ? words[pos] : 16'h0000;
         dec_busy = 1'b0;
         #1;
         check_val("done_single", 32'(done), 32'd0);
         check_val("idle_in_ready", 32'(in_ready), 32'd0);
         check_val("idle_valid", 32'(dec_data_in_valid), 32'd0);
         if (in_valid && in_ready) pos++;
      end
      in_valid = 1'b0;
      check_val("n_issued", 32'(got), 32'(exp_issued));
      check_val("items_issued", 32'(items_issued), 32'(exp_issued));
      check_val("error", 32'(error), 32'(exp_err));
      check_val("consumed", 32'(pos), 32'(exp_consumed));
`ifdef FEED_STATS_EN
      check_val("literal_cnt", 32'(literal_cnt), 32'(exp_lit));
      check_val("copy_cnt", 32'(copy_cnt), 32'(exp_copy));
`endif
   endtask

   initial begin
      // Reset held for three cycles
      reset = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check_idle_outputs("reset");
      @(negedge clock);
      reset = 1'b1;

      // Basic group: flags 1,0,1
      words = '{16'h00A0, 16'h0041, 16'h1003, 16'h0042, 16'h0000};
      run_stream(0, 0, 0, 1'b0);

      // Group rollover: ninth literal comes from word index 10
      words.delete();
      words.push_back(16'h0000);
      for (int i = 0; i < 8; i++) words.push_back(16'h0100 + 16'(i));
      words.push_back(16'h0000);
      words.push_back(16'h0BEE);
      words.push_back(16'h0000);
      run_stream(0, 0, 0, 1'b0);

      // Busy pacing: five busy cycles after every issue
      gen_random(12);
      run_stream(5, 5, 0, 1'b1);

      // Overflow, then a stream that must start with error cleared
      gen_random(MAX_ITEMS + 3);
      run_stream(0, 3, 20, 1'b1);
      gen_random(3);
      run_stream(0, 2, 10, 1'b0);

      // Reset during WAIT
      @(negedge clock); start = 1'b1; in_valid = 1'b0; dec_busy = 1'b0;
      @(negedge clock); start = 1'b0; in_valid = 1'b1; in_word = 16'h00FF;
      @(negedge clock); in_word = 16'h1234;
      @(negedge clock); in_valid = 1'b0;
      #1;
      check_val("mr_valid", 32'(dec_data_in_valid), 32'd1);
      check_val("mr_data", 32'(dec_data_in), 32'h1234);
      check_val("mr_flag", 32'(dec_control_word_in), 32'd1);
      @(negedge clock); dec_busy = 1'b1;
      @(negedge clock);
      #1;
      check_val("mr_items", 32'(items_issued), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_idle_outputs("midrst");
      @(negedge clock); reset = 1'b1; dec_busy = 1'b0;
      words = '{16'h00A0, 16'h0041, 16'h1003, 16'h0042, 16'h0000};
      run_stream(0, 0, 0, 1'b0);

      // Random streams
      for (int s = 0; s < 20; s++) begin
         gen_random($urandom_range(0, 20));
         run_stream(0, $urandom_range(0, 4), $urandom_range(0, 50), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
